led_trail_pwm: RTL and testbench

- Downstream display stage for the bouncing-ball physics core.
- Consumes the signed q8.24 ball position on each physics time step and maps it to one of NUM_LEDS bands with a sequential band-search FSM.
- Keeps a per-LED brightness level that decays over time, so the ball leaves a fading trail.
- Drives LEDR through a free-running PWM comparator. It replaces the combinational position-to-LEDR decode.

---
 rtl/led_trail_pwm_pkg.sv | 19 +
 rtl/led_trail_pwm_if.sv | 30 +++
 rtl/led_trail_pwm_comparator.sv | 35 +++
 rtl/led_trail_pwm.sv | 154 +++++++++++++++
 tb/tb_led_trail_pwm.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_trail_pwm_pkg.sv
// Shared definitions for the LED trail display stage.
// Contents:
//   Q824_W       - width of the signed q8.24 position word (shared with the physics core)
//   LEVEL_MAX    - full-brightness level value
//   SEG_SIZE_DEF - default band width in q8.24 units
//   state_t      - band-search FSM states
package led_trail_pkg;

    localparam int unsigned               Q824_W       = 32;
    localparam logic [7:0]                LEVEL_MAX    = 8'hFF;
    localparam logic signed [Q824_W-1:0]  SEG_SIZE_DEF = 32'sd1677721;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        UPDATE
    } state_t;

endpackage

// File: rtl/led_trail_pwm_if.sv
// Step/position bus between the step timer / physics core and the LED trail stage.
// Signals:
//   Position - signed q8.24 ball position
//   Step     - single-cycle time-step strobe
//   Enable   - qualifies Step
//   Index    - band index of the most recent completed update
//   Busy     - band search / update in progress
//   Overrun  - sticky: a Step was dropped
// Modports: master drives Position/Step/Enable, slave drives Index/Busy/Overrun.
interface led_trail_pwm_if;
    import led_trail_pkg::*;

    logic signed [Q824_W-1:0] Position;
    logic                     Step;
    logic                     Enable;
    logic [3:0]               Index;
    logic                     Busy;
    logic                     Overrun;

    modport master (
        output Position, Step, Enable,
        input  Index, Busy, Overrun
    );

    modport slave (
        input  Position, Step, Enable,
        output Index, Busy, Overrun
    );

endinterface

// File: rtl/led_trail_pwm_comparator.sv
// Free-running PWM generator for the LED bank.
// Ports:
//   i_clk   - system clock
//   i_rst_n - synchronous active-low reset
//   i_level - per-LED brightness levels
//   o_ledr  - registered PWM outputs, o_ledr[i] = level[i] > counter
module led_pwm_comparator #(
    parameter int unsigned NUM_LEDS = 10,
    parameter int unsigned LEVEL_W  = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [NUM_LEDS-1:0][LEVEL_W-1:0]  i_level,
    output logic [NUM_LEDS-1:0]               o_ledr
);

    logic [LEVEL_W-1:0]  r_pwm_cnt;
    logic [NUM_LEDS-1:0] r_ledr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pwm_cnt <= '0;
            r_ledr    <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            // Strict compare: level 0 never lights, full level lights all but one slot.
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                r_ledr[i] <= (i_level[i] > r_pwm_cnt);
            end
        end
    end

    assign o_ledr = r_ledr;

endmodule

// File: rtl/led_trail_pwm.sv
// LED trail display stage: maps each time-step position to a band with a
// sequential search, keeps decaying per-LED brightness levels and drives LEDR
// through a PWM comparator.
// Ports:
//   CLOCK_50 - system clock
//   Reset_n  - synchronous active-low reset
//   bus      - step/position bus (slave side): Position, Step, Enable in;
//              Index, Busy, Overrun out
//   LEDR     - PWM-modulated LED drive, registered
module led_trail_pwm
    import led_trail_pkg::*;
#(
    parameter int unsigned               NUM_LEDS    = 10,
    parameter int unsigned               LEVEL_W     = 8,
    parameter logic signed [Q824_W-1:0]  SEG_SIZE    = SEG_SIZE_DEF,
    parameter int unsigned               DECAY_DIV   = 16,
    parameter int unsigned               DECAY_SHIFT = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 Reset_n,
    led_trail_pwm_if.slave       bus,
    output logic [NUM_LEDS-1:0]  LEDR
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned DC_W  = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    state_t                             r_state, w_state_next;
    logic signed [Q824_W-1:0]           r_cap_pos;
    logic signed [Q824_W-1:0]           r_pend_pos;
    logic                               r_pend;
    logic                               r_overrun;
    logic [IDX_W-1:0]                   r_k;
    logic [IDX_W-1:0]                   r_res;
    logic [IDX_W-1:0]                   r_index;
    logic [DC_W-1:0]                    r_decay_cnt;
    logic [NUM_LEDS-1:0][LEVEL_W-1:0]   r_level;

    logic                               w_step;
    logic signed [Q824_W-1:0]           w_thresh;
    logic                               w_hit;
    logic                               w_capture;
    logic                               w_load_pend;
    logic                               w_done;
    logic [IDX_W-1:0]                   w_result;

    assign w_step   = bus.Step && bus.Enable;
    assign w_thresh = SEG_SIZE * $signed(Q824_W'(r_k) + Q824_W'(1));
    assign w_hit    = (r_cap_pos < w_thresh);
    assign w_result = w_hit ? r_k : IDX_W'(NUM_LEDS - 1);

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_load_pend  = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_step && !r_pend) begin
                    w_capture    = 1'b1;
                    w_state_next = SEARCH;
                end else if (r_pend) begin
                    w_load_pend  = 1'b1;
                    w_state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (w_hit || (r_k == IDX_W'(NUM_LEDS - 2))) begin
                    w_done       = 1'b1;
                    w_state_next = UPDATE;
                end
            end
            UPDATE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_cap_pos   <= '0;
            r_pend_pos  <= '0;
            r_pend      <= 1'b0;
            r_overrun   <= 1'b0;
            r_k         <= '0;
            r_res       <= '0;
            r_index     <= '0;
            r_decay_cnt <= '0;
            r_level     <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_capture) begin
                r_cap_pos <= bus.Position;
                r_k       <= '0;
            end else if (w_load_pend) begin
                r_cap_pos <= r_pend_pos;
                r_k       <= '0;
            end else if ((r_state == SEARCH) && !w_done) begin
                r_k <= r_k + 1'b1;
            end

            // A Step arriving while the pending slot is being drained refills
            // the slot, so Pending stays set in that case.
            if (w_load_pend) begin
                if (w_step) begin
                    r_pend_pos <= bus.Position;
                end else begin
                    r_pend <= 1'b0;
                end
            end else if (w_step && (r_state != IDLE)) begin
                if (!r_pend) begin
                    r_pend     <= 1'b1;
                    r_pend_pos <= bus.Position;
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            if (w_done) begin
                r_res <= w_result;
            end

            if (r_state == UPDATE) begin
                if (r_decay_cnt == DC_W'(DECAY_DIV - 1)) begin
                    r_decay_cnt <= '0;
                    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                        r_level[i] <= r_level[i] >> DECAY_SHIFT;
                    end
                end else begin
                    r_decay_cnt <= r_decay_cnt + 1'b1;
                end
                // Later assignment wins over the decay of the same entry.
                r_level[r_res] <= '1;
                r_index        <= r_res;
            end
        end
    end

    assign bus.Index   = r_index;
    assign bus.Busy    = (r_state != IDLE);
    assign bus.Overrun = r_overrun;

    led_pwm_comparator #(
        .NUM_LEDS (NUM_LEDS),
        .LEVEL_W  (LEVEL_W)
    ) u_pwm (
        .i_clk   (CLOCK_50),
        .i_rst_n (Reset_n),
        .i_level (r_level),
        .o_ledr  (LEDR)
    );

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed self-checking bench for led_trail_pwm.
module tb_led_trail_pwm;

    localparam int NL = 10;

    logic          clk;
    logic          rst_n;
    logic [NL-1:0] ledr;
    int            checks;
    int            errors;

    led_trail_pwm_if bus ();

    led_trail_pwm dut (
        .CLOCK_50 (clk),
        .Reset_n  (rst_n),
        .bus      (bus.slave),
        .LEDR     (ledr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    task automatic reset_dut();
        @(negedge clk);
        rst_n      = 1'b0;
        bus.Step   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives Step for exactly one rising edge; returns at the negedge after it.
    task automatic pulse_step(input logic signed [31:0] pos);
        bus.Position = pos;
        bus.Step     = 1'b1;
        @(negedge clk);
        bus.Step     = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.Busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.Busy !== 1'b0) begin
            $display("FAIL %s idle-wait: Busy=%b required 0 within 50 cycles", name, bus.Busy);
            errors++;
        end
    endtask

    // Counts cycles with LEDR[bit] high over 256 consecutive samples.
    task automatic duty(input int bit_i, output int cnt);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (ledr[bit_i]) cnt++;
        end
    endtask

    task automatic test_reset();
        int hi;
        reset_dut();
        checks++;
        if (ledr !== '0 || bus.Index !== 4'd0 || bus.Overrun !== 1'b0 || bus.Busy !== 1'b0) begin
            $display("FAIL reset_state: LEDR=%h Index=%0d Overrun=%b Busy=%b required 0/0/0/0",
                     ledr, bus.Index, bus.Overrun, bus.Busy);
            errors++;
        end
        hi = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (ledr !== '0) hi++;
        end
        checks++;
        if (hi !== 0) begin
            $display("FAIL reset_dark: LEDR nonzero in %0d cycles, required 0", hi);
            errors++;
        end
    endtask

    task automatic test_idx0();
        int c0, others;
        reset_dut();
        pulse_step(32'sd0);
        checks++;
        if (bus.Busy !== 1'b1) begin
            $display("FAIL idx0_busy1: Busy=%b required 1", bus.Busy);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (bus.Busy !== 1'b1) begin
            $display("FAIL idx0_busy2: Busy=%b required 1", bus.Busy);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (bus.Busy !== 1'b0 || bus.Index !== 4'd0) begin
            $display("FAIL idx0_done: Busy=%b Index=%0d required 0/0", bus.Busy, bus.Index);
            errors++;
        end
        repeat (3) @(negedge clk);
        c0 = 0;
        others = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (ledr[0]) c0++;
            if (ledr[NL-1:1] !== '0) others++;
        end
        checks++;
        if (c0 !== 255) begin
            $display("FAIL idx0_duty: LEDR[0] high %0d of 256, required 255", c0);
            errors++;
        end
        checks++;
        if (others !== 0) begin
            $display("FAIL idx0_others: other LEDs lit %0d cycles, required 0", others);
            errors++;
        end
    endtask

    task automatic band_latency(input string name, input logic signed [31:0] pos,
                                input logic [3:0] exp_idx, input int lat);
        pulse_step(pos);
        repeat (lat - 2) @(negedge clk);
        checks++;
        if (bus.Busy !== 1'b1) begin
            $display("FAIL %s_early: Busy=%b one cycle before done, required 1", name, bus.Busy);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (bus.Index !== exp_idx || bus.Busy !== 1'b0) begin
            $display("FAIL %s_index: Index=%0d Busy=%b after %0d cycles, required %0d/0",
                     name, bus.Index, bus.Busy, lat, exp_idx);
            errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_bands();
        band_latency("band5", 32'sd9000000, 4'd5, 8);
        band_latency("band9", 32'sh7F000000, 4'd9, 11);
        band_latency("bandneg", 32'shFF000000, 4'd0, 3);
    endtask

    task automatic test_decay();
        int c0, c9, cmid;
        reset_dut();
        pulse_step(32'sd0);
        wait_idle("decay_first");
        for (int s = 0; s < 15; s++) begin
            @(negedge clk);
            pulse_step(32'sh7F000000);
            wait_idle("decay_loop");
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.Index !== 4'd9) begin
            $display("FAIL decay_index: Index=%0d required 9", bus.Index);
            errors++;
        end
        duty(0, c0);
        checks++;
        if (c0 !== 127) begin
            $display("FAIL decay_led0: LEDR[0] high %0d of 256, required 127", c0);
            errors++;
        end
        duty(9, c9);
        checks++;
        if (c9 !== 255) begin
            $display("FAIL decay_led9: LEDR[9] high %0d of 256, required 255", c9);
            errors++;
        end
        duty(4, cmid);
        checks++;
        if (cmid !== 0) begin
            $display("FAIL decay_led4: LEDR[4] high %0d of 256, required 0", cmid);
            errors++;
        end
    endtask

    task automatic test_enable();
        int busy_hi, c0;
        bus.Enable = 1'b0;
        @(negedge clk);
        pulse_step(32'sd0);
        busy_hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.Busy) busy_hi++;
            @(negedge clk);
        end
        checks++;
        if (busy_hi !== 0) begin
            $display("FAIL enable_busy: Busy high %0d cycles, required 0", busy_hi);
            errors++;
        end
        checks++;
        if (bus.Index !== 4'd9 || bus.Overrun !== 1'b0) begin
            $display("FAIL enable_state: Index=%0d Overrun=%b required 9/0", bus.Index, bus.Overrun);
            errors++;
        end
        duty(0, c0);
        checks++;
        if (c0 !== 127) begin
            $display("FAIL enable_led0: LEDR[0] high %0d of 256, required 127", c0);
            errors++;
        end
        bus.Enable = 1'b1;
    endtask

    task automatic test_overrun();
        int c0;
        reset_dut();
        pulse_step(32'sh7F000000);
        @(negedge clk);
        pulse_step(32'sd9000000);
        checks++;
        if (bus.Overrun !== 1'b0) begin
            $display("FAIL ovr_early: Overrun=%b after second Step, required 0", bus.Overrun);
            errors++;
        end
        @(negedge clk);
        pulse_step(32'sd0);
        checks++;
        if (bus.Overrun !== 1'b1) begin
            $display("FAIL ovr_set: Overrun=%b after third Step, required 1", bus.Overrun);
            errors++;
        end
        repeat (6) @(negedge clk);
        checks++;
        if (bus.Index !== 4'd9) begin
            $display("FAIL ovr_first: Index=%0d required 9", bus.Index);
            errors++;
        end
        repeat (8) @(negedge clk);
        checks++;
        if (bus.Index !== 4'd5 || bus.Busy !== 1'b0) begin
            $display("FAIL ovr_pending: Index=%0d Busy=%b required 5/0", bus.Index, bus.Busy);
            errors++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if (bus.Index !== 4'd5 || bus.Busy !== 1'b0 || bus.Overrun !== 1'b1) begin
            $display("FAIL ovr_dropped: Index=%0d Busy=%b Overrun=%b required 5/0/1",
                     bus.Index, bus.Busy, bus.Overrun);
            errors++;
        end
        duty(0, c0);
        checks++;
        if (c0 !== 0) begin
            $display("FAIL ovr_led0: LEDR[0] high %0d of 256, required 0", c0);
            errors++;
        end
        reset_dut();
        checks++;
        if (bus.Overrun !== 1'b0) begin
            $display("FAIL ovr_clear: Overrun=%b after reset, required 0", bus.Overrun);
            errors++;
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.Position = '0;
        bus.Step     = 1'b0;
        bus.Enable   = 1'b1;
        test_reset();
        test_idx0();
        test_bands();
        test_decay();
        test_enable();
        test_overrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
